mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter that shares the single-channel, fixed-latency data memory between two cache requesters (port 0 and port 1). Each requester raises a block read (miss), a word write-through, or both together (store miss); the arbiter serialises requests, issues each to memory, waits for completion, and returns a one-cycle ready pulse plus block data to the granted requester. It sits between the cache controllers and the data memory.

## Interface
- BLOCK_SIZE, 4, words per block; read data width is 32*BLOCK_SIZE
- TIMEOUT, 63, watchdog limit in cycles for one memory transaction (used only with MEM_ARB_TIMEOUT_EN)
- Clk  input  1  clock, all state on rising edge
- Rst  input  1  reset, asynchronous, active-high
- ReqRead[1:0]  input  2  per-port block read request (bit p = port p), held until that port's ready pulse
- ReqWrite[1:0]  input  2  per-port word write request, held likewise; Read+Write together = store miss
- ReqAddr0, ReqAddr1  input  32  per-port byte address
- ReqWData0, ReqWData1  input  32  per-port write word
- ReadReady[1:0]  output  2  one-cycle pulse: read (or store miss) done for port p, ReadData valid
- WriteReady[1:0]  output  2  one-cycle pulse: pure write done for port p
- ReadData  output  32*BLOCK_SIZE  last completed block, shared by both ports
- Timeout  output  1  one-cycle pulse with the ready pulse when the watchdog aborted the transaction
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- MemAddr  output  32  memory address
- MemWData  output  32  memory write word
- MemRData  input  32*BLOCK_SIZE  memory block data
- MemReadReady, MemWriteReady  input  1 each  memory completion pulses

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: pending p = ReqRead[p]|ReqWrite[p]. None -> stay. One -> grant it. Both -> grant port != last_grant. Latch grant, read/write flags, address, wdata; go ISSUE.
- ISSUE (exactly 1 cycle): MemRead/MemWrite = latched flags, MemAddr/MemWData = latched values; go WAIT. Mem* request strobes are 0 in every other state; MemAddr/MemWData hold latched values.
- WAIT: completion = MemReadReady if read flag set (store miss and lw), else MemWriteReady. On completion latch MemRData into ReadData (read cases only), go RESP. Memory ready pulses that do not match the pending type are ignored.
- RESP (1 cycle): ReadReady[g] pulses if read flag, else WriteReady[g]; last_grant <= g; go IDLE.
- Requester must drop its request at the edge where it samples its ready; arbiter re-arbitrates from IDLE next cycle, so back-to-back requests from both ports alternate.
- Requests changing while not in IDLE are ignored; the other port simply waits.
- A port with neither bit set is never granted.

## Timing
- Reset: state IDLE, last_grant = 1 (port 0 wins first tie), all Ready/Timeout/MemRead/MemWrite = 0, MemAddr, MemWData, ReadData = 0, watchdog = 0.
- Reset mid-transaction: immediate return to IDLE; no ready pulse for the aborted request.
- Latency: request seen at edge k (IDLE) -> ISSUE cycle k+1 -> memory completion pulse at cycle m -> ready pulse in cycle m+1. Overhead is 2 cycles beyond memory latency.
- Minimum idle gap between two grants: 1 cycle (IDLE).

## Configuration
- MEM_ARB_TIMEOUT_EN defined: 8-bit watchdog counts cycles in WAIT; reaching TIMEOUT forces RESP with Timeout pulsing alongside the normal ready pulse, ReadData unchanged, counter cleared. Late memory pulses for the aborted request arrive in IDLE/ISSUE and are ignored.
- Undefined: no counter, WAIT waits indefinitely, Timeout tied to 0.

## Structure
- Shared package: state encoding constants (IDLE/ISSUE/WAIT/RESP), BLOCK_SIZE default, word width 32.
- One sub-module: rr_arbiter2 (2-way round-robin grant from pending bits and last_grant, combinational); FSM and latches stay in mem_arbiter.

## Test plan
- Port 0 read 0x40 alone, memory completes 20 cycles after ISSUE with block 0x4_3_2_1 -> ReadReady=01 exactly one cycle, ReadData=that block, MemRead high one cycle with MemAddr=0x40.
- Ports 0 and 1 both write in same cycle (0x10<-0xAA, 0x20<-0xBB) -> port 0 served first, then port 1; memory sees two MemWrite pulses in that order; WriteReady 01 then 10.
- Port 1 store miss 0x30 data 0x55 -> MemRead and MemWrite both high in ISSUE; completion only on MemReadReady; ReadReady=10, WriteReady stays 00.
- Both ports issue continuous reads for 4 transactions -> grants alternate 0,1,0,1.
- Rst asserted during WAIT of port 0 read -> outputs 0 immediately, no ready pulse; later memory pulse ignored.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=63, memory never responds -> ready and Timeout pulse together 63 cycles after entering WAIT; arbiter returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants and types for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int MA_WORD_W     = 32;
  localparam int MA_BLOCK_SIZE = 4;
  localparam int MA_TIMEOUT    = 63;

  // Controller state encoding, kept as plain constants for legacy tools
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // One captured request: operation flags plus address and write word
  typedef struct packed {
    logic                 rd;
    logic                 wr;
    logic [MA_WORD_W-1:0] addr;
    logic [MA_WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the arbiter.
// The arbiter uses the slave view; requesters and memory use the master view.
interface mem_arbiter_if #(
  parameter int BLOCK_SIZE = mem_arbiter_pkg::MA_BLOCK_SIZE
);
  import mem_arbiter_pkg::*;

  // Requester side
  logic [1:0]                      ReqRead;
  logic [1:0]                      ReqWrite;
  logic [MA_WORD_W-1:0]            ReqAddr0;
  logic [MA_WORD_W-1:0]            ReqAddr1;
  logic [MA_WORD_W-1:0]            ReqWData0;
  logic [MA_WORD_W-1:0]            ReqWData1;
  logic [1:0]                      ReadReady;
  logic [1:0]                      WriteReady;
  logic [MA_WORD_W*BLOCK_SIZE-1:0] ReadData;
  logic                            Timeout;

  // Memory side
  logic                            MemRead;
  logic                            MemWrite;
  logic [MA_WORD_W-1:0]            MemAddr;
  logic [MA_WORD_W-1:0]            MemWData;
  logic [MA_WORD_W*BLOCK_SIZE-1:0] MemRData;
  logic                            MemReadReady;
  logic                            MemWriteReady;

  modport slave (
    input  ReqRead, ReqWrite, ReqAddr0, ReqAddr1, ReqWData0, ReqWData1,
    input  MemRData, MemReadReady, MemWriteReady,
    output ReadReady, WriteReady, ReadData, Timeout,
    output MemRead, MemWrite, MemAddr, MemWData
  );

  modport master (
    output ReqRead, ReqWrite, ReqAddr0, ReqAddr1, ReqWData0, ReqWData1,
    output MemRData, MemReadReady, MemWriteReady,
    input  ReadReady, WriteReady, ReadData, Timeout,
    input  MemRead, MemWrite, MemAddr, MemWData
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick from pending bits.
module rr_arbiter2 (
  input  logic [1:0] pending_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       grant_o
);

  // A lone requester always wins; a tie goes to the port that did not win last
  always_comb begin
    valid_o = |pending_i;
    case (pending_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_grant_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises block reads / word writes from two cache ports onto
// one fixed-latency memory channel, round-robin on ties.
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts a transaction after TIMEOUT cycles and flags it on Timeout.
module mem_arbiter #(
  parameter int BLOCK_SIZE = mem_arbiter_pkg::MA_BLOCK_SIZE
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = mem_arbiter_pkg::MA_TIMEOUT
`endif
) (
  input logic          Clk,
  input logic          Rst,
  mem_arbiter_if.slave bus
);
  import mem_arbiter_pkg::*;

  localparam int RD_W = MA_WORD_W * BLOCK_SIZE;

  logic [1:0]      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  req_t            req_q, req_d, arb_req_s;
  logic [1:0]      pending_s;
  logic            arb_valid_s, arb_grant_s;
  logic            done_s, expired_s;
  logic            mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [1:0]      rd_rdy_q, rd_rdy_d, wr_rdy_q, wr_rdy_d;
  logic            timeout_q, timeout_d;
  logic [RD_W-1:0] rdata_q, rdata_d;

  assign pending_s = bus.ReqRead | bus.ReqWrite;

  rr_arbiter2 u_rr (
    .pending_i    (pending_s),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid_s),
    .grant_o      (arb_grant_s)
  );

  // Request fields of the arbitration winner, ready to be captured in IDLE
  always_comb begin
    arb_req_s.rd    = arb_grant_s ? bus.ReqRead[1]  : bus.ReqRead[0];
    arb_req_s.wr    = arb_grant_s ? bus.ReqWrite[1] : bus.ReqWrite[0];
    arb_req_s.addr  = arb_grant_s ? bus.ReqAddr1    : bus.ReqAddr0;
    arb_req_s.wdata = arb_grant_s ? bus.ReqWData1   : bus.ReqWData0;
  end

  // Reads (including store misses) finish on MemReadReady only; pure writes on MemWriteReady
  assign done_s = req_q.rd ? bus.MemReadReady : bus.MemWriteReady;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;

  assign expired_s = (state_q == ST_WAIT) && !done_s && (wdog_q == 8'(TIMEOUT - 1));

  // Watchdog counts WAIT cycles and clears whenever the transaction leaves WAIT
  always_comb begin
    if ((state_q == ST_WAIT) && !done_s && !expired_s) begin
      wdog_d = wdog_q + 8'd1;
    end else begin
      wdog_d = 8'd0;
    end
  end

  // Watchdog register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wdog_q <= 8'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign expired_s = 1'b0;
`endif

  // Next-state and registered-output decode for IDLE/ISSUE/WAIT/RESP
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    req_d        = req_q;
    rdata_d      = rdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    rd_rdy_d     = 2'b00;
    wr_rdy_d     = 2'b00;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          grant_d  = arb_grant_s;
          req_d    = arb_req_s;
          mem_rd_d = arb_req_s.rd;
          mem_wr_d = arb_req_s.wr;
          state_d  = ST_ISSUE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_s || expired_s) begin
          if (done_s && req_q.rd) begin
            rdata_d = bus.MemRData;
          end else begin
            rdata_d = rdata_q;
          end
          if (req_q.rd) begin
            rd_rdy_d[grant_q] = 1'b1;
          end else begin
            wr_rdy_d[grant_q] = 1'b1;
          end
          timeout_d = expired_s;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured request and all registered outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      req_q        <= '0;
      rdata_q      <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      rd_rdy_q     <= 2'b00;
      wr_rdy_q     <= 2'b00;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      rd_rdy_q     <= rd_rdy_d;
      wr_rdy_q     <= wr_rdy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.ReadReady  = rd_rdy_q;
  assign bus.WriteReady = wr_rdy_q;
  assign bus.ReadData   = rdata_q;
  assign bus.Timeout    = timeout_q;
  assign bus.MemRead    = mem_rd_q;
  assign bus.MemWrite   = mem_wr_q;
  assign bus.MemAddr    = req_q.addr;
  assign bus.MemWData   = req_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven, hand-written and randomized checks of mem_arbiter
// against a transaction-level model (service order, memory requests, ready pulses).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int BS      = 4;
  localparam int RW      = 32 * BS;
  localparam int TIMEOUT = 63;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  mem_arbiter_if #(.BLOCK_SIZE(BS)) bus ();
  mem_arbiter #(.BLOCK_SIZE(BS)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  typedef struct { int cyc; logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [RW-1:0] blk; } memreq_t;
  typedef struct { int cyc; logic [1:0] rr; logic [1:0] wr; logic to; logic [RW-1:0] data; } rdy_t;
  typedef struct { int port; logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; } xact_t;
  typedef struct { logic [1:0] op0; logic [1:0] op1; logic [31:0] a0; logic [31:0] a1;
                   logic [31:0] d0; logic [31:0] d1; int lat; logic [RW-1:0] blk; int exp_n; int exp_first; } vec_t;

  memreq_t       memlog[$];
  rdy_t          rdylog[$];
  xact_t         exp_q[$];
  logic [RW-1:0] blk_q[$];

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            mem_lat = 1;
  int            mem_cnt = 0;
  int            mem_cur_lat = 1;
  logic          mem_busy = 1'b0;
  logic          mem_rd = 1'b0;
  logic [RW-1:0] mem_blk = '0;
  int            model_last = 1;
  logic [RW-1:0] model_rdata = '0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_blk();
    logic [RW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // One clock: memory model, requester model and event logging, all at edge+1
  task automatic step();
    memreq_t mr;
    rdy_t    rv;
    @(posedge Clk);
    #1;
    cyc++;
    bus.MemReadReady  = 1'b0;
    bus.MemWriteReady = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_busy = 1'b0;
        if (mem_rd) begin
          bus.MemReadReady = 1'b1;
          bus.MemRData     = mem_blk;
        end else begin
          bus.MemWriteReady = 1'b1;
        end
      end else if (mem_cnt == mem_cur_lat - 1) begin
        // wrong-type completion pulse; the arbiter must ignore it
        if (mem_rd) bus.MemWriteReady = 1'b1;
        else        bus.MemReadReady  = 1'b1;
      end
    end
    if (bus.MemRead || bus.MemWrite) begin
      mr.cyc = cyc; mr.rd = bus.MemRead; mr.wr = bus.MemWrite;
      mr.addr = bus.MemAddr; mr.wdata = bus.MemWData;
      if (blk_q.size() > 0) mr.blk = blk_q.pop_front();
      else                  mr.blk = rand_blk();
      memlog.push_back(mr);
      mem_busy = 1'b1; mem_cnt = mem_lat; mem_cur_lat = mem_lat;
      mem_rd = bus.MemRead; mem_blk = mr.blk;
    end
    if (bus.ReadReady != 2'b00 || bus.WriteReady != 2'b00) begin
      rv.cyc = cyc; rv.rr = bus.ReadReady; rv.wr = bus.WriteReady;
      rv.to = bus.Timeout; rv.data = bus.ReadData;
      rdylog.push_back(rv);
      for (int p = 0; p < 2; p++) begin
        if (bus.ReadReady[p] || bus.WriteReady[p]) begin
          bus.ReqRead[p]  = 1'b0;
          bus.ReqWrite[p] = 1'b0;
        end
      end
    end
  endtask

  function automatic xact_t mk(input int port, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    xact_t x;
    x.port = port; x.rd = op[0]; x.wr = op[1]; x.addr = a; x.wdata = d;
    return x;
  endfunction

  // Present both ports' requests together, serve them, compare against the expected order
  task automatic run_vec(input string tag, input logic [1:0] op0, input logic [1:0] op1,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0,
                         input logic [31:0] d1, input int lat, input int first, input logic exp_to);
    int base, budget, elat;
    logic [1:0] bit_p;
    memlog.delete(); rdylog.delete(); exp_q.delete();
    mem_lat = lat;
    if (op0 != 2'b00 && op1 != 2'b00) begin
      if (first == 0) begin exp_q.push_back(mk(0, op0, a0, d0)); exp_q.push_back(mk(1, op1, a1, d1)); end
      else            begin exp_q.push_back(mk(1, op1, a1, d1)); exp_q.push_back(mk(0, op0, a0, d0)); end
    end else if (op0 != 2'b00) begin
      exp_q.push_back(mk(0, op0, a0, d0));
    end else if (op1 != 2'b00) begin
      exp_q.push_back(mk(1, op1, a1, d1));
    end
    bus.ReqRead  = {op1[0], op0[0]};
    bus.ReqWrite = {op1[1], op0[1]};
    bus.ReqAddr0 = a0; bus.ReqAddr1 = a1; bus.ReqWData0 = d0; bus.ReqWData1 = d1;
    base   = cyc;
    budget = 2 * (lat + 8) + 20;
    while (rdylog.size() < exp_q.size() && budget > 0) begin step(); budget--; end
    budget = 100;
    while (mem_busy && budget > 0) begin step(); budget--; end
    repeat (3) step();
    elat = exp_to ? (TIMEOUT + 1) : (lat + 1);
    check({tag, " mem_req_count"}, RW'(memlog.size()), RW'(exp_q.size()));
    check({tag, " ready_count"},   RW'(rdylog.size()), RW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < memlog.size()) begin
        check({tag, " MemRead"},  RW'(memlog[i].rd),    RW'(exp_q[i].rd));
        check({tag, " MemWrite"}, RW'(memlog[i].wr),    RW'(exp_q[i].wr));
        check({tag, " MemAddr"},  RW'(memlog[i].addr),  RW'(exp_q[i].addr));
        check({tag, " MemWData"}, RW'(memlog[i].wdata), RW'(exp_q[i].wdata));
        if (i == 0)                check({tag, " issue_cycle"}, RW'(memlog[i].cyc), RW'(base + 1));
        else if (i - 1 < rdylog.size()) check({tag, " issue_gap"}, RW'(memlog[i].cyc), RW'(rdylog[i-1].cyc + 2));
      end
      if (i < rdylog.size() && i < memlog.size()) begin
        bit_p = (exp_q[i].port == 0) ? 2'b01 : 2'b10;
        if (exp_q[i].rd && !exp_to) model_rdata = memlog[i].blk;
        check({tag, " ReadReady"},  RW'(rdylog[i].rr), exp_q[i].rd ? RW'(bit_p) : RW'(0));
        check({tag, " WriteReady"}, RW'(rdylog[i].wr), exp_q[i].rd ? RW'(0) : RW'(bit_p));
        check({tag, " Timeout"},    RW'(rdylog[i].to), RW'(exp_to));
        check({tag, " latency"},    RW'(rdylog[i].cyc - memlog[i].cyc), RW'(elat));
        check({tag, " ReadData"},   rdylog[i].data, model_rdata);
      end
    end
    if (exp_q.size() > 0) begin
      check({tag, " MemAddr_hold"}, RW'(bus.MemAddr), RW'(exp_q[exp_q.size()-1].addr));
      model_last = exp_q[exp_q.size()-1].port;
    end
  endtask

  vec_t    tbl[9];
  logic [1:0]  o0, o1;
  int      first, budget;

  initial begin
    bus.ReqRead = 2'b00; bus.ReqWrite = 2'b00;
    bus.ReqAddr0 = 32'd0; bus.ReqAddr1 = 32'd0; bus.ReqWData0 = 32'd0; bus.ReqWData1 = 32'd0;
    bus.MemRData = '0; bus.MemReadReady = 1'b0; bus.MemWriteReady = 1'b0;

    tbl[0] = '{2'b10, 2'b10, 32'h10,  32'h20,  32'hAA, 32'hBB, 3,  '0, 2, 0};
    tbl[1] = '{2'b01, 2'b00, 32'h40,  32'h0,   32'h0,  32'h0,  20, {32'h4, 32'h3, 32'h2, 32'h1}, 1, 0};
    tbl[2] = '{2'b00, 2'b11, 32'h0,   32'h30,  32'h0,  32'h55, 5,  '0, 1, 1};
    tbl[3] = '{2'b01, 2'b01, 32'h100, 32'h200, 32'h0,  32'h0,  4,  '0, 2, 0};
    tbl[4] = '{2'b01, 2'b01, 32'h104, 32'h204, 32'h0,  32'h0,  2,  '0, 2, 0};
    tbl[5] = '{2'b10, 2'b11, 32'h300, 32'h304, 32'h11, 32'h22, 1,  '0, 2, 0};
    tbl[6] = '{2'b10, 2'b00, 32'h400, 32'h0,   32'h33, 32'h0,  2,  '0, 1, 0};
    tbl[7] = '{2'b01, 2'b10, 32'h500, 32'h504, 32'h0,  32'h44, 3,  '0, 2, 1};
    tbl[8] = '{2'b00, 2'b00, 32'h600, 32'h604, 32'h0,  32'h0,  3,  '0, 0, 0};

    // reset state
    #1;
    check("rst ReadReady",  RW'(bus.ReadReady),  RW'(0));
    check("rst WriteReady", RW'(bus.WriteReady), RW'(0));
    check("rst Timeout",    RW'(bus.Timeout),    RW'(0));
    check("rst MemRead",    RW'({bus.MemRead, bus.MemWrite}), RW'(0));
    check("rst MemAddr",    RW'({bus.MemAddr, bus.MemWData}), RW'(0));
    check("rst ReadData",   bus.ReadData, RW'(0));
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b0;
    step();

    // directed table
    for (int v = 0; v < 9; v++) begin
      if (tbl[v].blk != '0) blk_q.push_back(tbl[v].blk);
      run_vec($sformatf("vec%0d", v), tbl[v].op0, tbl[v].op1, tbl[v].a0, tbl[v].a1,
              tbl[v].d0, tbl[v].d1, tbl[v].lat, tbl[v].exp_first, 1'b0);
      check($sformatf("vec%0d n", v), RW'(rdylog.size()), RW'(tbl[v].exp_n));
    end
    check("block 4321", bus.ReadData, model_rdata);

    // reset during WAIT of a port-0 read
    memlog.delete(); rdylog.delete(); mem_lat = 30;
    bus.ReqRead = 2'b01; bus.ReqWrite = 2'b00; bus.ReqAddr0 = 32'h80;
    budget = 10;
    while (memlog.size() == 0 && budget > 0) begin step(); budget--; end
    check("rstw issued", RW'(memlog.size()), RW'(1));
    repeat (3) step();
    #2;
    Rst = 1'b1; bus.ReqRead = 2'b00;
    #1;
    check("rstw ready",    RW'({bus.ReadReady, bus.WriteReady, bus.Timeout}), RW'(0));
    check("rstw mem",      RW'({bus.MemRead, bus.MemWrite}), RW'(0));
    check("rstw MemAddr",  RW'(bus.MemAddr), RW'(0));
    check("rstw ReadData", bus.ReadData, RW'(0));
    step(); step();
    Rst = 1'b0;
    repeat (40) step();
    check("rstw no_ready", RW'(rdylog.size()), RW'(0));
    check("rstw ReadData_after", bus.ReadData, RW'(0));
    model_last = 1; model_rdata = '0;
    run_vec("post_rst_tie", 2'b01, 2'b10, 32'h700, 32'h704, 32'h0, 32'h66, 2, 0, 1'b0);

    // slow memory: beyond the watchdog limit when it is built in
`ifdef MEM_ARB_TIMEOUT_EN
    run_vec("slow_mem", 2'b01, 2'b00, 32'h800, 32'h0, 32'h0, 32'h0, 70, 0, 1'b1);
`else
    run_vec("slow_mem", 2'b01, 2'b00, 32'h800, 32'h0, 32'h0, 32'h0, 70, 0, 1'b0);
`endif

    // randomized traffic against the round-robin model
    for (int it = 0; it < 40; it++) begin
      o0 = 2'($urandom_range(0, 3));
      o1 = 2'($urandom_range(0, 3));
      if (o0 != 2'b00 && o1 != 2'b00) first = (model_last == 0) ? 1 : 0;
      else                            first = (o0 != 2'b00) ? 0 : 1;
      run_vec($sformatf("rnd%0d", it), o0, o1, $urandom, $urandom, $urandom, $urandom,
              int'($urandom_range(1, 8)), first, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
